// File: rtl/apb_regfile_completer.sv
// APB completer exposing a bank of byte-strobed RW registers and hw_in-sourced RO registers,
// with a fixed number of wait states per access and pslverr on bad decode or RO writes.
module apb_regfile_completer #(
  parameter int                   ADDR_W      = 32,
  parameter int                   DATA_W      = 32,
  parameter int                   NUM_REGS    = 8,
  parameter int                   WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam int                NB         = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [3:0]          wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       strb_q;
  logic                pready_q;
  logic                pslverr_q;
  logic [DATA_W-1:0]   prdata_q;

  logic [DATA_W-1:0]   reg_arr [NUM_REGS];
  logic [DATA_W-1:0]   hw_arr  [NUM_REGS];

  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_write;
  logic [IDX_W-1:0]    cur_idx;
  logic                in_range;
  logic                is_ro;
  logic                dec_err;
  logic [DATA_W-1:0]   rd_value;
  logic                commit_w;
  logic [IDX_W-1:0]    commit_idx;

  // With zero wait states the response is decided on the setup edge, before addr_q is loaded.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? paddr  : addr_q;
    cur_write = (state_q == IDLE) ? pwrite : write_q;
    cur_idx   = cur_addr[2 +: IDX_W];
    in_range  = (cur_addr < ADDR_LIMIT);
    is_ro     = in_range && RO_MASK[cur_idx];
    dec_err   = (cur_addr[1:0] != 2'b00) || !in_range || (cur_write && is_ro);
    rd_value  = '0;
    if (in_range) begin
      rd_value = is_ro ? hw_arr[cur_idx] : reg_arr[cur_idx];
    end
  end

  assign commit_w   = (state_q == ACCESS) && pready_q && psel && write_q && !pslverr_q;
  assign commit_idx = addr_q[2 +: IDX_W];

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q <= ACCESS;
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            wcnt_q  <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
              prdata_q  <= (!cur_write && !dec_err) ? rd_value : '0;
            end
          end
        end
        ACCESS: begin
          if (!psel || pready_q) begin
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
              prdata_q  <= (!cur_write && !dec_err) ? rd_value : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign hw_arr[gi] = hw_in[gi*DATA_W +: DATA_W];
    if (RO_MASK[gi]) begin : g_ro
      logic [DATA_W-1:0] val_q;
      always_ff @(posedge pclk) begin
        val_q <= hw_arr[gi];
      end
      assign reg_arr[gi] = val_q;
    end else begin : g_rw
      logic [DATA_W-1:0] val_q;
      always_ff @(posedge pclk) begin
        if (reset) begin
          val_q <= RESET_VAL;
        end else if (commit_w && (commit_idx == IDX_W'(gi))) begin
          for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) begin
              val_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end
      assign reg_arr[gi] = val_q;
    end
    assign reg_out[gi*DATA_W +: DATA_W] = reg_arr[gi];
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: dut0 has no wait states and reg 7 read-only,
// dut2 has two wait states and all registers read/write.
module tb_apb_regfile_completer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              reset;
  logic              psel0, psel2, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [3:0]        pstrb;
  logic [NR*DW-1:0]  hw_in;
  logic              pready0, pslverr0, pready2, pslverr2;
  logic [DW-1:0]     prdata0, prdata2;
  logic [NR*DW-1:0]  reg_out0, reg_out2;

  apb_regfile_completer #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(0),
    .RO_MASK(8'h80), .RESET_VAL(32'h0)
  ) dut0 (
    .pclk(pclk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .hw_in(hw_in), .reg_out(reg_out0)
  );

  apb_regfile_completer #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(2),
    .RO_MASK(8'h00), .RESET_VAL(32'h0)
  ) dut2 (
    .pclk(pclk), .reset(reset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready2), .prdata(prdata2),
    .pslverr(pslverr2), .hw_in(hw_in), .reg_out(reg_out2)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m0 [NR];
  logic [31:0] m2 [NR];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic bus_idle();
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge; leaves psel high so transfers can chain.
  task automatic apb_do(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int wt, output bit ok);
    rd = '0; er = 1'b0; wt = 0; ok = 1'b0;
    if (k == 0) begin psel0 = 1'b1; psel2 = 1'b0; end
    else        begin psel2 = 1'b1; psel0 = 1'b0; end
    penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if ((k == 0) ? pready0 : pready2) begin
        rd = (k == 0) ? prdata0 : prdata2;
        er = (k == 0) ? pslverr0 : pslverr2;
        ok = 1'b1;
        break;
      end
      wt++;
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
  endtask

  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string nm, output logic [31:0] rd,
                      output logic er, output int wt, output bit ok);
    exp_t       e;
    logic [7:0] ro;
    int         idx;
    ro  = (k == 0) ? 8'h80 : 8'h00;
    idx = int'(a[4:2]);
    e.err   = (a[1:0] != 2'b00) || (a >= 32'h20) || (w && ro[idx]);
    e.rdata = '0;
    if (!w && !e.err) e.rdata = ro[idx] ? hw_in[idx*32 +: 32] : ((k == 0) ? m0[idx] : m2[idx]);
    e.waits = (k == 0) ? 0 : 2;
    e.name  = nm;
    exp_q.push_back(e);
    apb_do(k, w, a, d, s, rd, er, wt, ok);
    if (w && !e.err) begin
      if (k == 0) m0[idx] = merge(m0[idx], d, s);
      else        m2[idx] = merge(m2[idx], d, s);
    end
    $display("txn %s dut%0d %s addr=%h wdata=%h strb=%b -> rdata=%h err=%b waits=%0d",
             nm, k, w ? "WR" : "RD", a, d, s, rd, er, wt);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    reset = 1'b1;
    bus_idle();
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk); #1;
      checks++;
      if (pready0 !== 1'b0 || pready2 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs: pready0=%b pready2=%b pslverr0=%b prdata0=%h, want all 0",
                 pready0, pready2, pslverr0, prdata0);
      end
    end
    reset = 1'b0;
    @(posedge pclk); #1;
    for (int i = 0; i < NR; i++) begin
      xfer(2, 1'b0, 32'(i*4), 32'h0, 4'h0, "reset_read", rd, er, wt, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rd !== e.rdata || er !== e.err || wt != e.waits || e.rdata !== 32'h0) begin
        failures++;
        $display("FAIL %s[%0d]: got rdata=%h err=%b waits=%0d ok=%0b, want rdata=00000000 err=0 waits=2",
                 e.name, i, rd, er, wt, ok);
      end
    end
    bus_idle();
  endtask

  task automatic test_full_write();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, "full_write", rd, er, wt, ok);
    bus_idle();
    checks++;
    if (pready0 !== 1'b0) begin
      failures++;
      $display("FAIL pready_one_cycle: pready0=%b after completion, want 0", pready0);
    end
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, "full_read", rd, er, wt, ok);
    bus_idle();
    repeat (2) begin
      e = exp_q.pop_front();
      checks++;
      if (!ok || er !== e.err || wt != e.waits) begin
        failures++;
        $display("FAIL %s: got err=%b waits=%0d ok=%0b, want err=%b waits=%0d",
                 e.name, er, wt, ok, e.err, e.waits);
      end
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL full_read_data: got %h, want deadbeef", rd);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    logic [31:0] wd [3];
    logic [3:0]  sb [3];
    wd[0] = 32'h11223344; sb[0] = 4'hF;
    wd[1] = 32'hAABBCCDD; sb[1] = 4'b0101;
    wd[2] = 32'h99999999; sb[2] = 4'h0;
    for (int i = 0; i < 3; i++) begin
      xfer(0, 1'b1, 32'h0C, wd[i], sb[i], "strobe_write", rd, er, wt, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || er !== e.err || wt != e.waits) begin
        failures++;
        $display("FAIL %s[%0d]: got err=%b waits=%0d ok=%0b, want err=%b waits=%0d",
                 e.name, i, er, wt, ok, e.err, e.waits);
      end
    end
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, "strobe_read", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || rd !== 32'h11BB33DD || er !== 1'b0) begin
      failures++;
      $display("FAIL %s: got rdata=%h err=%b, want rdata=11bb33dd err=0", e.name, rd, er);
    end
    checks++;
    if (reg_out0[3*32 +: 32] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_reg_out: got %h, want 11bb33dd", reg_out0[3*32 +: 32]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    xfer(2, 1'b1, 32'h10, 32'h5A5A1234, 4'hF, "ws_write", rd, er, wt, ok);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, "ws_read", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || rd !== 32'h5A5A1234 || er !== e.err || wt != 2) begin
      failures++;
      $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=5a5a1234 err=0 waits=2",
               e.name, rd, er, wt);
    end
    // Aborted write: psel dropped after the first access cycle.
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hFFFF0000; pstrb = 4'hF;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; bus_idle();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (pready2 !== 1'b0) begin
        failures++;
        $display("FAIL abort_pready: cycle %0d pready2=%b, want 0", c, pready2);
      end
      @(posedge pclk); #1;
    end
    checks++;
    if (reg_out2[5*32 +: 32] !== m2[5]) begin
      failures++;
      $display("FAIL abort_no_write: reg5=%h, want %h", reg_out2[5*32 +: 32], m2[5]);
    end
    $display("txn abort dut2 WR addr=00000014 reg5=%h", reg_out2[5*32 +: 32]);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    logic [31:0] ad [3];
    bit          wr [3];
    ad[0] = 32'h20; wr[0] = 1'b0;
    ad[1] = 32'h06; wr[1] = 1'b1;
    ad[2] = 32'h1C; wr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(0, wr[i], ad[i], 32'hFFFFFFFF, 4'hF, "error", rd, er, wt, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || er !== 1'b1 || e.err !== 1'b1 || rd !== 32'h0 || wt != e.waits) begin
        failures++;
        $display("FAIL %s[%0d]: got rdata=%h err=%b waits=%0d ok=%0b, want rdata=00000000 err=1 waits=0",
                 e.name, i, rd, er, wt, ok);
      end
    end
    bus_idle();
    @(posedge pclk); #1;
    checks++;
    if (reg_out0[1*32 +: 32] !== m0[1] || reg_out0[7*32 +: 32] !== hw_in[7*32 +: 32]) begin
      failures++;
      $display("FAIL error_no_change: reg1=%h reg7=%h, want reg1=%h reg7=%h",
               reg_out0[1*32 +: 32], reg_out0[7*32 +: 32], m0[1], hw_in[7*32 +: 32]);
    end
  endtask

  task automatic test_ro();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, "ro_read", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || rd !== 32'h0000CAFE || er !== 1'b0) begin
      failures++;
      $display("FAIL %s: got rdata=%h err=%b, want rdata=0000cafe err=0", e.name, rd, er);
    end
    hw_in[7*32 +: 32] = 32'h0000BEEF;
    @(posedge pclk); #1;
    checks++;
    if (reg_out0[7*32 +: 32] !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL ro_mirror: reg_out slice7=%h, want 0000beef", reg_out0[7*32 +: 32]);
    end
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, "ro_read_new", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== 1'b0) begin
      failures++;
      $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=0", e.name, rd, er, e.rdata);
    end
    hw_in[7*32 +: 32] = 32'h0000CAFE;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    time t0;
    t0 = $time;
    xfer(0, 1'b1, 32'h10, 32'hC0FFEE01, 4'hF, "b2b_write", rd, er, wt, ok);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "b2b_read", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || rd !== 32'hC0FFEE01 || ($time - t0) != 40) begin
      failures++;
      $display("FAIL %s: got rdata=%h elapsed=%0t, want rdata=c0ffee01 elapsed=40",
               e.name, rd, $time - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int wt; bit ok; exp_t e;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1; penable = 1'b1; reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk); #1;
      checks++;
      if (pready2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_pready: cycle %0d pready2=%b, want 0", c, pready2);
      end
    end
    bus_idle();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin m0[i] = 32'h0; m2[i] = 32'h0; end
    @(posedge pclk); #1;
    checks++;
    if (reg_out2[6*32 +: 32] !== 32'h0 || reg_out0[2*32 +: 32] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_regs: dut2 reg6=%h dut0 reg2=%h, want 0",
               reg_out2[6*32 +: 32], reg_out0[2*32 +: 32]);
    end
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, "post_reset_read", rd, er, wt, ok);
    bus_idle();
    e = exp_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      failures++;
      $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b", e.name, rd, er, e.rdata, e.err);
    end
  endtask

  initial begin
    reset = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < NR; i++) begin
      hw_in[i*32 +: 32] = 32'hA5000000 | 32'(i);
      m0[i] = 32'h0;
      m2[i] = 32'h0;
    end
    hw_in[7*32 +: 32] = 32'h0000CAFE;
    test_reset();
    test_full_write();
    test_strobes();
    test_wait_states();
    test_errors();
    test_ro();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
